// File: rtl/hatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hatch_pkg
// Description : Shared state encoding and display stage constants for the
//               incubation sequencer and the dot-matrix driver.
// Revision    : 1.0 - initial release
// ============================================================================
package hatch_pkg;

    localparam int DISP_NUM_W    = 4;
    localparam int LAST_GROW_DEF = 8;
    localparam int NUM_HATCHED   = LAST_GROW_DEF + 1;
    localparam int DEAD_NUM_DEF  = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_FAULT   = 3'd2,
        ST_HATCHED = 3'd3,
        ST_DEAD    = 3'd4
    } hatch_state_e;

endpackage
`default_nettype wire

// File: rtl/hatch_sequencer_sync.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic 2-flop level synchronizer, async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/hatch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hatch_sequencer
// Description : Egg incubation stage sequencer driving the dot-matrix display.
// Revision    : 1.0 - initial release
// ============================================================================
module hatch_sequencer
    import hatch_pkg::*;
#(
    parameter int STAGE_MS   = 1000,
    parameter int LAST_GROW  = LAST_GROW_DEF,
    parameter int RECOVER_MS = 200,
    parameter int DEAD_MS    = 5000,
    parameter int DEAD_NUM   = DEAD_NUM_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st,
    input  logic                  temp_ok,
    output logic [DISP_NUM_W-1:0] num,
    output logic                  temp,
    output logic                  disp_en,
    output logic                  busy,
    output logic                  done,
    output logic                  dead
);

    localparam int c_ms_w  = $clog2(STAGE_MS) + 1;
    localparam int c_rec_w = $clog2(RECOVER_MS) + 1;
    localparam int c_flt_w = $clog2(DEAD_MS) + 1;

    localparam logic [c_ms_w-1:0]     c_ms_last   = c_ms_w'(STAGE_MS - 1);
    localparam logic [c_rec_w-1:0]    c_rec_lim   = c_rec_w'(RECOVER_MS);
    localparam logic [c_flt_w-1:0]    c_flt_lim   = c_flt_w'(DEAD_MS);
    localparam logic [DISP_NUM_W-1:0] c_num_last  = DISP_NUM_W'(LAST_GROW);
    localparam logic [DISP_NUM_W-1:0] c_num_hatch = DISP_NUM_W'(LAST_GROW + 1);
    localparam logic [DISP_NUM_W-1:0] c_num_dead  = DISP_NUM_W'(DEAD_NUM);

    logic                  w_tok;
    hatch_state_e          r_state, w_state_nxt;
    logic [c_ms_w-1:0]     r_ms, w_ms_nxt;
    logic [c_rec_w-1:0]    r_rec, w_rec_nxt;
    logic [c_flt_w-1:0]    r_flt, w_flt_nxt;
    logic [DISP_NUM_W-1:0] r_num, w_num_nxt;
    logic                  r_temp, r_disp_en, r_busy, r_done, r_dead;

    sync_2ff #(
        .WIDTH (1)
    ) u_tok_sync (
        .clk (clk),
        .rst (rst),
        .d   (temp_ok),
        .q   (w_tok)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ms_nxt    = r_ms;
        w_rec_nxt   = r_rec;
        w_flt_nxt   = r_flt;
        w_num_nxt   = r_num;

        // Dropping the run enable overrides every other transition.
        if (!st) begin
            w_state_nxt = ST_IDLE;
            w_ms_nxt    = '0;
            w_rec_nxt   = '0;
            w_flt_nxt   = '0;
            w_num_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_RUN;
                    w_ms_nxt    = '0;
                    w_rec_nxt   = '0;
                    w_flt_nxt   = '0;
                    w_num_nxt   = '0;
                end
                ST_RUN: begin
                    if (!w_tok) begin
                        w_state_nxt = ST_FAULT;
                        w_flt_nxt   = c_flt_w'(1);
                        w_rec_nxt   = '0;
                    end else if (r_ms == c_ms_last) begin
                        w_ms_nxt = '0;
                        if (r_num == c_num_last) begin
                            w_num_nxt   = c_num_hatch;
                            w_state_nxt = ST_HATCHED;
                        end else if (r_num < c_num_last) begin
                            w_num_nxt = r_num + DISP_NUM_W'(1);
                        end
                    end else if (r_ms < c_ms_last) begin
                        w_ms_nxt = r_ms + c_ms_w'(1);
                    end
                end
                ST_FAULT: begin
                    // ms_cnt is untouched here so progress resumes where it froze.
                    if (!w_tok) begin
                        w_rec_nxt = '0;
                        if (r_flt != c_flt_lim) begin
                            w_flt_nxt = r_flt + c_flt_w'(1);
                        end
                        if (w_flt_nxt == c_flt_lim) begin
                            w_state_nxt = ST_DEAD;
                            w_num_nxt   = c_num_dead;
                        end
                    end else begin
                        if (r_rec != c_rec_lim) begin
                            w_rec_nxt = r_rec + c_rec_w'(1);
                        end
                        if (w_rec_nxt == c_rec_lim) begin
                            w_state_nxt = ST_RUN;
                            w_rec_nxt   = '0;
                            w_flt_nxt   = '0;
                        end
                    end
                end
                ST_HATCHED: w_num_nxt = c_num_hatch;
                ST_DEAD:    w_num_nxt = c_num_dead;
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_num_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ms      <= '0;
            r_rec     <= '0;
            r_flt     <= '0;
            r_num     <= '0;
            r_temp    <= 1'b0;
            r_disp_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dead    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ms      <= w_ms_nxt;
            r_rec     <= w_rec_nxt;
            r_flt     <= w_flt_nxt;
            r_num     <= w_num_nxt;
            r_temp    <= (w_state_nxt == ST_FAULT) || (w_state_nxt == ST_DEAD);
            r_disp_en <= (w_state_nxt != ST_IDLE);
            r_busy    <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_FAULT);
            r_done    <= (w_state_nxt == ST_HATCHED);
            r_dead    <= (w_state_nxt == ST_DEAD);
        end
    end

    assign num     = r_num;
    assign temp    = r_temp;
    assign disp_en = r_disp_en;
    assign busy    = r_busy;
    assign done    = r_done;
    assign dead    = r_dead;

endmodule
`default_nettype wire

// File: doc/hatch_sequencer.md
Name: hatch_sequencer

Overview:
Incubation controller that sequences the 8x8 dot-matrix display stage index. From the 1 kHz display clock it advances the egg-growth stage number over time while the temperature is in range. It freezes progress and raises the red-overlay flag on a temperature fault, and declares the egg dead if the fault persists. Outputs feed the dot-matrix driver's num, temp and st inputs directly.

Parameters:
STAGE_MS, 1000, clk cycles spent in each growth stage (1 kHz clk -> ms)
LAST_GROW, 8, final growth stage index; stage LAST_GROW+1 is the hatched image
RECOVER_MS, 200, consecutive in-range cycles required to leave FAULT
DEAD_MS, 5000, consecutive fault cycles after which the egg is dead
DEAD_NUM, 10, stage index shown when dead

Ports:
clk  in  1  1 kHz system/display clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
st  in  1  run enable level; 0 aborts to IDLE
temp_ok  in  1  temperature-in-range level, asynchronous to clk
num  out  4  stage index to dot-matrix driver
temp  out  1  fault overlay flag to dot-matrix driver (1 = show red)
disp_en  out  1  display enable to dot-matrix st input
busy  out  1  1 in RUN or FAULT
done  out  1  1 in HATCHED
dead  out  1  1 in DEAD

Behaviour:
- temp_ok passes through a 2-flop synchronizer; all logic uses the synced value tok. Sync flops reset to 0.
- Reset (rst=0, async): state=IDLE, num=0, temp=0, disp_en=0, busy=done=dead=0, ms_cnt=0, rec_cnt=0, flt_cnt=0.
- States: IDLE, RUN, FAULT, HATCHED, DEAD; all outputs are registered.
- IDLE: num=0, disp_en=0. On st=1 go to RUN next cycle; num=0, disp_en=1, ms_cnt=0.
- RUN, tok=1: ms_cnt increments each cycle. At ms_cnt==STAGE_MS-1, ms_cnt wraps to 0 and num increments. If num was LAST_GROW, num becomes LAST_GROW+1 and the state moves to HATCHED in the same edge.
- RUN, tok=0: go to FAULT. ms_cnt holds its value (progress is frozen, not lost). temp=1, flt_cnt=1, rec_cnt=0.
- FAULT: temp=1, num held.
  - tok=0: flt_cnt increments and rec_cnt clears. When flt_cnt reaches DEAD_MS, go to DEAD.
  - tok=1: rec_cnt increments. When rec_cnt reaches RECOVER_MS, go to RUN with temp=0 and flt_cnt=0. Counting resumes from the frozen ms_cnt.
  - A glitch of tok=0 during recovery clears rec_cnt but does not clear flt_cnt. flt_cnt clears only on return to RUN.
- HATCHED: num=LAST_GROW+1, done=1, temp=0, disp_en=1. tok is ignored. Held until st=0.
- DEAD: num=DEAD_NUM, dead=1, temp=1, disp_en=1. Held until st=0.
- st=0 in any non-IDLE state: synchronously return to IDLE next edge. Takes priority over every other transition in the same cycle. All counters clear.
- st=1 held after HATCHED/DEAD does not restart. A new run needs st to go 0 and then 1.
- Counters are sized with $clog2 of their limit plus 1 and must not wrap; compares are equality with saturation guard.
- num never exceeds 4'd11.
- Async reset mid-run returns everything to reset values immediately, with no partial stage retained.

Decomposition:
- Shared package hatch_pkg holds:
  - the state enum typedef
  - stage constants: NUM_HATCHED = LAST_GROW+1, DEAD_NUM default
  - DISP_NUM_W = 4, also used by the dot-matrix driver
- Natural sub-module: sync_2ff, a generic 2-flop level synchronizer with async active-low reset, reused for other panel inputs.

Test Plan:
- Parameters STAGE_MS=4, RECOVER_MS=3, DEAD_MS=6, LAST_GROW=8 for all tests; rst=0 then 1.
- st=1, tok=1 constant -> num steps 0,1,...,8 every 4 clk, reaches 9 with done=1 at 36 cycles after RUN entry (+2 sync cycles); busy drops at the same edge.
- In RUN with num=3 and ms_cnt=2, drive temp_ok=0 for 2 cycles then 1 -> temp=1, num stays 3. Leave FAULT after 3 synced-high cycles; num becomes 4 after exactly 2 further RUN cycles.
- temp_ok=0 held 6+ synced cycles in RUN -> state DEAD, num=10, dead=1, temp=1; held while st=1.
- In FAULT, pattern tok 1,1,0,1,1,1 -> rec_cnt restarts at the 0. Exit only after the final three 1s; a dead-limit crossing in the same window takes DEAD.
- st=0 on the same cycle as a stage-wrap edge -> IDLE wins, num=0, disp_en=0. Reassert st=1 -> restarts at num=0. Assert rst=0 mid-RUN -> all outputs 0 without waiting for clk.
